// File: rtl/spi_slave_wb_pkg.sv
// Shared register map, STATUS/CTRL bit positions and SPI FSM encoding for spi_slave_wb.
// Firmware header generation reads the same constants.
package spi_slave_wb_pkg;

    localparam logic [1:0] REG_RXDATA = 2'd0;
    localparam logic [1:0] REG_TXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int ST_RX_EMPTY = 0;
    localparam int ST_RX_FULL  = 1;
    localparam int ST_TX_PEND  = 2;
    localparam int ST_RX_OVR   = 3;
    localparam int ST_TX_UND   = 4;
    localparam int ST_BUSY     = 5;

    localparam int CTRL_RX_IE = 0;
    localparam int CTRL_TX_IE = 1;
    localparam int CTRL_EN    = 2;

    typedef enum logic {
        SPI_IDLE  = 1'b0,
        SPI_SHIFT = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_slave_wb_rx_fifo.sv
// RX word FIFO: single clock, head visible combinationally on dout_o, latency 1 push-to-visible.
// A push while full is refused unless a pop happens in the same cycle.
module spi_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/spi_slave_wb.sv
// Wishbone SPI mode-0 slave: oversampled pins, RX FIFO, single TX holding register; WB ack latency 1.
// No SPI backpressure: a word arriving at a full FIFO is dropped and flagged as overrun.
module spi_slave_wb
    import spi_slave_wb_pkg::*;
#(
    parameter int DATA_LENGTH = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    output logic        wb_ack_o,
    output logic        intr,
    input  logic        spi_sclk,
    input  logic        spi_ss_n,
    input  logic        spi_mosi,
    output logic        spi_miso
);

    localparam int W  = DATA_LENGTH;
    localparam int BW = $clog2(DATA_LENGTH + 1);

    logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic ss_meta_q, ss_sync_q, ss_prev_q;
    logic mosi_meta_q, mosi_sync_q;

    spi_state_e     state_q, state_d;
    logic [BW-1:0]  bit_cnt_q, bit_cnt_d, bit_cnt_inc;
    logic [W-1:0]   rx_sh_q, rx_sh_d;
    logic [W-1:0]   tx_sh_q, tx_sh_d;
    logic [W-1:0]   hold_q, hold_d;
    logic           tx_pend_q, tx_pend_d;
    logic           ovr_q, ovr_d;
    logic           und_q, und_d;
    logic [2:0]     ctrl_q, ctrl_d;
    logic           ack_q;
    logic [31:0]    rdat_q, rdat_d;
    logic           intr_q, intr_d;

    logic           sclk_rise, sclk_fall, ss_fall, ss_rise;
    logic           access, wr, rd, enable, reload;
    logic [1:0]     reg_sel;
    logic [5:0]     status_vec;
    logic [W:0]     rx_cat;
    logic [W-1:0]   rx_word, fifo_dout;
    logic           fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic           unused_ok;

    assign unused_ok = ^{wb_sel_i, wb_adr_i, wb_dat_i};

    assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall = ~sclk_sync_q & sclk_prev_q;
    assign ss_fall   = ~ss_sync_q & ss_prev_q;
    assign ss_rise   = ss_sync_q & ~ss_prev_q;

    assign access  = wb_stb_i & wb_cyc_i & ~ack_q;
    assign wr      = access & wb_we_i;
    assign rd      = access & ~wb_we_i;
    assign reg_sel = wb_adr_i[3:2];
    assign enable  = ctrl_q[CTRL_EN];

    assign rx_cat      = {rx_sh_q, mosi_sync_q};
    assign rx_word     = rx_cat[W-1:0];
    assign bit_cnt_inc = bit_cnt_q + BW'(1);
    assign status_vec  = {~ss_sync_q & enable, und_q, ovr_q, tx_pend_q, fifo_full, fifo_empty};

    assign wb_ack_o = ack_q;
    assign wb_dat_o = rdat_q;
    assign intr     = intr_q;
    assign spi_miso = (state_q == SPI_SHIFT) ? tx_sh_q[W-1] : 1'b0;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_sh_d   = rx_sh_q;
        tx_sh_d   = tx_sh_q;
        hold_d    = hold_q;
        tx_pend_d = tx_pend_q;
        ovr_d     = ovr_q;
        und_d     = und_q;
        ctrl_d    = ctrl_q;
        rdat_d    = '0;
        fifo_push = 1'b0;
        reload    = 1'b0;
        fifo_pop  = rd & (reg_sel == REG_RXDATA) & ~fifo_empty;

        case (state_q)
            SPI_IDLE: begin
                if (ss_fall && enable) begin
                    state_d   = SPI_SHIFT;
                    bit_cnt_d = '0;
                    reload    = 1'b1;
                end
            end
            SPI_SHIFT: begin
                if (ss_rise || !enable) begin
                    state_d   = SPI_IDLE;
                    bit_cnt_d = '0;
                end else if (sclk_rise) begin
                    rx_sh_d = rx_word;
                    if (bit_cnt_inc == BW'(DATA_LENGTH)) begin
                        fifo_push = 1'b1;
                        bit_cnt_d = '0;
                        reload    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_inc;
                    end
                end else if (sclk_fall) begin
                    tx_sh_d = tx_sh_q << 1;
                end
            end
            default: state_d = SPI_IDLE;
        endcase

        // Reload sees the pre-write holding state; a same-cycle CPU write lands after it.
        if (reload) begin
            tx_sh_d   = tx_pend_q ? hold_q : '0;
            tx_pend_d = 1'b0;
        end
        if (wr && reg_sel == REG_TXDATA) begin
            hold_d    = wb_dat_i[W-1:0];
            tx_pend_d = 1'b1;
        end
        if (wr && reg_sel == REG_CTRL) ctrl_d = wb_dat_i[2:0];
        if (wr && reg_sel == REG_STATUS) begin
            if (wb_dat_i[ST_RX_OVR]) ovr_d = 1'b0;
            if (wb_dat_i[ST_TX_UND]) und_d = 1'b0;
        end
        if (fifo_push && fifo_full && !fifo_pop) ovr_d = 1'b1;
        if (reload && !tx_pend_q)                und_d = 1'b1;

        if (rd) begin
            case (reg_sel)
                REG_RXDATA: rdat_d = fifo_empty ? 32'd0 : 32'(fifo_dout);
                REG_STATUS: rdat_d = 32'(status_vec);
                REG_CTRL:   rdat_d = 32'(ctrl_q);
                default:    rdat_d = '0;
            endcase
        end

        intr_d = (ctrl_q[CTRL_RX_IE] & ~fifo_empty) | (ctrl_q[CTRL_TX_IE] & ~tx_pend_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            ss_meta_q   <= 1'b1;
            ss_sync_q   <= 1'b1;
            ss_prev_q   <= 1'b1;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            state_q     <= SPI_IDLE;
            bit_cnt_q   <= '0;
            rx_sh_q     <= '0;
            tx_sh_q     <= '0;
            hold_q      <= '0;
            tx_pend_q   <= 1'b0;
            ovr_q       <= 1'b0;
            und_q       <= 1'b0;
            ctrl_q      <= '0;
            ack_q       <= 1'b0;
            rdat_q      <= '0;
            intr_q      <= 1'b0;
        end else begin
            sclk_meta_q <= spi_sclk;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            ss_meta_q   <= spi_ss_n;
            ss_sync_q   <= ss_meta_q;
            ss_prev_q   <= ss_sync_q;
            mosi_meta_q <= spi_mosi;
            mosi_sync_q <= mosi_meta_q;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sh_q     <= rx_sh_d;
            tx_sh_q     <= tx_sh_d;
            hold_q      <= hold_d;
            tx_pend_q   <= tx_pend_d;
            ovr_q       <= ovr_d;
            und_q       <= und_d;
            ctrl_q      <= ctrl_d;
            ack_q       <= access;
            rdat_q      <= rdat_d;
            intr_q      <= intr_d;
        end
    end

    spi_rx_fifo #(
        .WIDTH (DATA_LENGTH),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (rx_word),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

endmodule
